// File: rtl/boss_pkg.sv
// boss_pkg -- shared types and default constants for the boss health controller.
//   boss_state_e   : FSM state encoding (IDLE, ALIVE, IFRAME, DEAD)
//   DEF_*          : default health, damage, invulnerability and regen-period values
package boss_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    IFRAME = 2'd2,
    DEAD   = 2'd3
  } boss_state_e;

  localparam int DEF_MAX_HP    = 100;
  localparam int DEF_ARROW_DMG = 2;
  localparam int DEF_MELEE_DMG = 5;
  localparam int DEF_IFRAMES   = 8;
  localparam int REGEN_PERIOD  = 64;  // hit-free frame_ticks per regenerated HP point

endpackage

// File: rtl/boss_hp_ctl_if.sv
// boss_hp_ctl_if -- game-side signal bundle of the boss health controller.
//   frame_tick     : one-clk pulse per video frame
//   game_active    : 2'b00 = menu/inactive, anything else = fight running
//   projectile_hit : one-clk pulse, an arrow struck the boss
//   melee_hit      : one-clk pulse, a melee swing struck the boss
//   boss_hp        : current health (registered)
//   boss_alive     : health > 0 in a running fight (registered)
//   boss_hit_flash : high while invulnerable (registered)
//   boss_defeated  : one-clk pulse on the death transition (registered)
// All signals are level/pulse qualified; there is no valid/ready handshake:
// pulses are sampled on the rising clk edge at which they are high.
// Modports: master drives the game events, slave is the controller.
interface boss_hp_ctl_if;
  logic       frame_tick;
  logic [1:0] game_active;
  logic       projectile_hit;
  logic       melee_hit;
  logic [7:0] boss_hp;
  logic       boss_alive;
  logic       boss_hit_flash;
  logic       boss_defeated;

  modport master (
    output frame_tick, game_active, projectile_hit, melee_hit,
    input  boss_hp, boss_alive, boss_hit_flash, boss_defeated
  );

  modport slave (
    input  frame_tick, game_active, projectile_hit, melee_hit,
    output boss_hp, boss_alive, boss_hit_flash, boss_defeated
  );
endinterface

// File: rtl/boss_iframe_timer.sv
// boss_iframe_timer -- frame-counted invulnerability timer.
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : load i_load_val into the counter
//   i_load_val   : invulnerability length in frame_ticks
//   i_clear      : force the counter to 0 (wins over load)
//   i_frame_tick : decrement strobe
//   o_busy       : counter non-zero
//   o_last       : frame_tick arriving while the counter is 1 (window ends this edge)
module boss_iframe_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clear,
  input  logic         i_frame_tick,
  output logic         o_busy,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_frame_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_last = i_frame_tick && (r_cnt == W'(1));

endmodule

// File: rtl/boss_hp_ctl.sv
// boss_hp_ctl -- boss health / invulnerability / death controller.
//   clk, rst     : system clock, asynchronous active-high reset
//   bus (slave)  : game events in, registered health/status out (boss_hp_ctl_if)
//   o_dbg_state  : current FSM state, for observation only
// Parameters: BOSS_MAX_HP (1..255), ARROW_DMG, MELEE_DMG, IFRAMES.
// Optional feature: define BOSS_REGEN_EN to regenerate 1 HP after every
// REGEN_PERIOD consecutive hit-free frame_ticks spent in ALIVE.
module boss_hp_ctl
  import boss_pkg::*;
#(
  parameter int BOSS_MAX_HP = DEF_MAX_HP,
  parameter int ARROW_DMG   = DEF_ARROW_DMG,
  parameter int MELEE_DMG   = DEF_MELEE_DMG,
  parameter int IFRAMES     = DEF_IFRAMES
) (
  input  logic          clk,
  input  logic          rst,
  boss_hp_ctl_if.slave  bus,
  output boss_state_e   o_dbg_state
);

  localparam logic [7:0] MAX_HP_C  = 8'(BOSS_MAX_HP);
  localparam logic [8:0] ARROW_C   = 9'(ARROW_DMG);
  localparam logic [8:0] MELEE_C   = 9'(MELEE_DMG);
  localparam logic [7:0] IFRAMES_C = 8'(IFRAMES);

  boss_state_e r_state, w_state_nxt;
  logic [7:0]  r_hp, w_hp_nxt;
  logic        r_alive, r_flash, r_defeated, w_defeated_nxt;
  logic [8:0]  w_dmg, w_hp_sub;
  logic        w_hit, w_fight, w_load, w_clear, w_busy, w_last, w_regen_inc;

  // Damage is summed and subtracted at 9 bits so a big hit saturates at 0.
  assign w_fight  = (bus.game_active != 2'b00);
  assign w_dmg    = (bus.projectile_hit ? ARROW_C : 9'd0) + (bus.melee_hit ? MELEE_C : 9'd0);
  assign w_hit    = (w_dmg != 9'd0);
  assign w_hp_sub = (w_dmg >= {1'b0, r_hp}) ? 9'd0 : ({1'b0, r_hp} - w_dmg);

`ifdef BOSS_REGEN_EN
  localparam int RW = $clog2(REGEN_PERIOD);
  logic [RW-1:0] r_regen_cnt;

  // Counts only hit-free ticks in ALIVE; anything else restarts the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regen_cnt <= '0;
    end else if ((r_state != ALIVE) || !w_fight || w_hit) begin
      r_regen_cnt <= '0;
    end else if (bus.frame_tick) begin
      r_regen_cnt <= (r_regen_cnt == RW'(REGEN_PERIOD - 1)) ? '0 : r_regen_cnt + RW'(1);
    end
  end

  assign w_regen_inc = (r_state == ALIVE) && w_fight && !w_hit && bus.frame_tick &&
                       (r_regen_cnt == RW'(REGEN_PERIOD - 1));
`else
  assign w_regen_inc = 1'b0;
`endif

  boss_iframe_timer #(.W(8)) u_iframe_timer (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_val   (IFRAMES_C),
    .i_clear      (w_clear),
    .i_frame_tick (bus.frame_tick),
    .o_busy       (w_busy),
    .o_last       (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hp       <= MAX_HP_C;
      r_alive    <= 1'b0;
      r_flash    <= 1'b0;
      r_defeated <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hp       <= w_hp_nxt;
      r_alive    <= (w_state_nxt == ALIVE) || (w_state_nxt == IFRAME);
      r_flash    <= (w_state_nxt == IFRAME);
      r_defeated <= w_defeated_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hp_nxt       = r_hp;
    w_defeated_nxt = 1'b0;
    w_load         = 1'b0;
    w_clear        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_hp_nxt = MAX_HP_C;
        if (w_fight) w_state_nxt = ALIVE;
      end
      ALIVE: begin
        if (w_hit) begin
          w_hp_nxt = w_hp_sub[7:0];
          if (w_hp_sub == 9'd0) begin
            w_state_nxt    = DEAD;
            w_defeated_nxt = 1'b1;
          end else if (IFRAMES_C != 8'd0) begin
            w_state_nxt = IFRAME;
            w_load      = 1'b1;
          end
        end else if (w_regen_inc && (r_hp < MAX_HP_C)) begin
          w_hp_nxt = r_hp + 8'd1;
        end
      end
      IFRAME: begin
        // !w_busy is a safety exit; normally the window ends on w_last.
        if (w_last || !w_busy) w_state_nxt = ALIVE;
      end
      DEAD: begin
        w_hp_nxt = 8'd0;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Leaving the fight overrides everything, including hits this clk.
    if (!w_fight) begin
      w_state_nxt    = IDLE;
      w_hp_nxt       = MAX_HP_C;
      w_defeated_nxt = 1'b0;
      w_load         = 1'b0;
      w_clear        = 1'b1;
    end
  end

  assign bus.boss_hp        = r_hp;
  assign bus.boss_alive     = r_alive;
  assign bus.boss_hit_flash = r_flash;
  assign bus.boss_defeated  = r_defeated;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_boss_hp_ctl.sv
// tb_boss_hp_ctl -- directed bench for boss_hp_ctl with an expected-value queue.
// Each entry packs {boss_hp, boss_alive, boss_hit_flash, boss_defeated}.
module tb_boss_hp_ctl;
  import boss_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  boss_hp_ctl_if bus ();
  boss_state_e   dbg_state;

  boss_hp_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [7:0] hp, input logic alive, input logic flash,
                            input logic def);
    exp_q.push_back({hp, alive, flash, def});
  endtask

  task automatic check(input string tag);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {bus.boss_hp, bus.boss_alive, bus.boss_hit_flash, bus.boss_defeated};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: no expected entry queued, observed hp=%0d", tag, obs[10:3]);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: got hp=%0d alive=%b flash=%b defeated=%b, expected hp=%0d alive=%b flash=%b defeated=%b",
               tag, obs[10:3], obs[2], obs[1], obs[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic check_state(input string tag, input boss_state_e exp);
    checks++;
    assert (dbg_state === exp) else begin
      errors++;
      $error("FAIL %s: got state=%0d, expected state=%0d", tag, dbg_state, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic hit(input logic p, input logic m);
    bus.projectile_hit = p;
    bus.melee_hit      = m;
    step();
    bus.projectile_hit = 1'b0;
    bus.melee_hit      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic set_game(input logic [1:0] ga);
    bus.game_active = ga;
    step();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] m_hp;
    rst                = 1'b1;
    bus.frame_tick     = 1'b0;
    bus.game_active    = 2'b00;
    bus.projectile_hit = 1'b0;
    bus.melee_hit      = 1'b0;
    repeat (3) step();
    expect_out(8'd100, 1'b0, 1'b0, 1'b0); check("reset_held");
    check_state("reset_state", IDLE);
    rst = 1'b0;
    step();
    expect_out(8'd100, 1'b0, 1'b0, 1'b0); check("idle_after_reset");

    // Fight starts.
    set_game(2'b01);
    expect_out(8'd100, 1'b1, 1'b0, 1'b0); check("start");
    step();
    expect_out(8'd100, 1'b1, 1'b0, 1'b0); check("start_hold");
    check_state("start_state", ALIVE);

    // Arrow, then melee ignored during invulnerability, then 8-tick window.
    hit(1'b1, 1'b0);
    expect_out(8'd98, 1'b1, 1'b1, 1'b0); check("arrow");
    hit(1'b0, 1'b1);
    expect_out(8'd98, 1'b1, 1'b1, 1'b0); check("melee_in_iframe");
    ticks(7);
    expect_out(8'd98, 1'b1, 1'b1, 1'b0); check("iframe_tick7");
    ticks(1);
    expect_out(8'd98, 1'b1, 1'b0, 1'b0); check("iframe_tick8");

    // Refill, then simultaneous hits.
    set_game(2'b00);
    expect_out(8'd100, 1'b0, 1'b0, 1'b0); check("refill");
    set_game(2'b10);
    expect_out(8'd100, 1'b1, 1'b0, 1'b0); check("restart");
    hit(1'b1, 1'b1);
    expect_out(8'd93, 1'b1, 1'b1, 1'b0); check("both_hits");
    ticks(8);
    expect_out(8'd93, 1'b1, 1'b0, 1'b0); check("both_exit");

    // Melee down to 3 HP.
    m_hp = 8'd93;
    for (int i = 0; i < 18; i++) begin
      m_hp = m_hp - 8'd5;
      hit(1'b0, 1'b1);
      expect_out(m_hp, 1'b1, 1'b1, 1'b0); check("melee_chain");
      ticks(8);
      expect_out(m_hp, 1'b1, 1'b0, 1'b0); check("melee_chain_exit");
    end

    // Saturating kill.
    hit(1'b0, 1'b1);
    expect_out(8'd0, 1'b0, 1'b0, 1'b1); check("kill");
    check_state("kill_state", DEAD);
    step();
    expect_out(8'd0, 1'b0, 1'b0, 1'b0); check("defeated_one_clk");
    hit(1'b1, 1'b1);
    ticks(2);
    expect_out(8'd0, 1'b0, 1'b0, 1'b0); check("dead_hits");

    // Leave the fight from IFRAME with a simultaneous hit; hits in IDLE dropped.
    set_game(2'b00);
    expect_out(8'd100, 1'b0, 1'b0, 1'b0); check("dead_to_idle");
    set_game(2'b01);
    hit(1'b1, 1'b0);
    expect_out(8'd98, 1'b1, 1'b1, 1'b0); check("arrow_again");
    bus.game_active = 2'b00;
    hit(1'b0, 1'b1);
    expect_out(8'd100, 1'b0, 1'b0, 1'b0); check("abort_iframe");
    check_state("abort_state", IDLE);
    hit(1'b1, 1'b1);
    expect_out(8'd100, 1'b0, 1'b0, 1'b0); check("idle_hit");
    set_game(2'b11);
    expect_out(8'd100, 1'b1, 1'b0, 1'b0); check("restart2");

    // Regeneration: 90 HP then 64 hit-free ticks in ALIVE.
    hit(1'b0, 1'b1); ticks(8);
    hit(1'b0, 1'b1); ticks(8);
    expect_out(8'd90, 1'b1, 1'b0, 1'b0); check("hp90");
    ticks(63);
    expect_out(8'd90, 1'b1, 1'b0, 1'b0); check("regen_tick63");
    ticks(1);
`ifdef BOSS_REGEN_EN
    expect_out(8'd91, 1'b1, 1'b0, 1'b0); check("regen_tick64");
`else
    expect_out(8'd90, 1'b1, 1'b0, 1'b0); check("no_regen_tick64");
`endif
    set_game(2'b00);
    set_game(2'b01);
    ticks(64);
    expect_out(8'd100, 1'b1, 1'b0, 1'b0); check("regen_cap");

    // Asynchronous reset mid-fight, observed before any clock edge.
    hit(1'b1, 1'b0);
    expect_out(8'd98, 1'b1, 1'b1, 1'b0); check("pre_reset_hit");
    #2 rst = 1'b1;
    #1;
    expect_out(8'd100, 1'b0, 1'b0, 1'b0); check("async_reset");
    check_state("async_reset_state", IDLE);
    step();
    rst = 1'b0;
    step();
    expect_out(8'd100, 1'b1, 1'b0, 1'b0); check("after_reset_fight");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expected entries never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
